fir_coeff_ctrl: RTL
===================

FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 Parameter: NTAPS, 33, number of filter taps.
REQ-002 Parameter: CW, 16, coefficient width in bits.
REQ-003 Parameter: LAT, 4, FIR datapath latency in cycles from sample input to filter output.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset. The ports are named clk and rst.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 cfg_start  in  1  single-cycle pulse that begins or restarts a coefficient load.
REQ-008 cfg_valid  in  1  coefficient beat valid.
REQ-009 cfg_ready  out  1  controller accepts a coefficient beat.
REQ-010 cfg_data  in  CW  coefficient value.
REQ-011 cfg_last  in  1  marks the final beat of a load.
REQ-012 commit  in  1  single-cycle pulse that applies the shadow bank.
REQ-013 load_err  out  1  one-cycle pulse on a malformed load.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 coeff_flat  out  NTAPS*CW  active bank; tap k occupies bits [CW*k+CW-1 : CW*k].
REQ-016 in_valid  in  1  sample presented to the FIR datapath this cycle.
REQ-017 out_valid  out  1  FIR output this cycle is valid.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, ARMED and FLUSH.
REQ-019 IDLE: cfg_ready=0; cfg_start moves to LOAD and sets idx to 0.
REQ-020 LOAD: cfg_ready=1; each beat where cfg_valid and cfg_ready are both high writes shadow[idx] = cfg_data, then increments idx.
REQ-021 LOAD: a beat with idx==NTAPS-1 and cfg_last=1 moves to ARMED.
REQ-022 LOAD: a beat with cfg_last=1 and idx<NTAPS-1, or with idx==NTAPS-1 and cfg_last=0, pulses load_err for one cycle and returns to IDLE. The shadow bank is treated as invalid and the active bank is unchanged.
REQ-023 LOAD or ARMED: cfg_start restarts the load (state LOAD, idx=0). If cfg_start and a beat coincide, cfg_start wins and the beat is dropped.
REQ-024 ARMED: commit copies the full shadow bank into the active bank at the same clock edge and moves to FLUSH; coeff_flat shows the new values in the cycle after commit.
REQ-025 commit in any state other than ARMED is ignored. cfg_start in FLUSH is ignored.
REQ-026 FLUSH lasts exactly NTAPS+LAT cycles, counted by a down-counter, then returns to IDLE; out_valid is forced to 0 throughout FLUSH.
REQ-027 out_valid SHALL equal in_valid delayed by LAT cycles through a shift register, ANDed with (state != FLUSH). The shift register keeps running during FLUSH.
REQ-028 The active bank SHALL change only on commit or reset; coefficients are opaque two's-complement values and are never modified.

Reset
REQ-029 When rst is asserted, at any time including mid-LOAD or mid-FLUSH, the block SHALL immediately:
- set state to IDLE and idx, flush counter and valid shift register to 0;
- clear the shadow and active banks to 0;
- drive cfg_ready, load_err, busy and out_valid to 0, and coeff_flat to 0.

Configuration
REQ-030 When macro FIR_CTRL_READBACK_EN is defined, the block SHALL add these ports:
- rd_idx  in  6  tap select;
- rd_data  out  CW  combinational readback of active[rd_idx], or 0 when rd_idx >= NTAPS.
REQ-031 When FIR_CTRL_READBACK_EN is undefined, rd_idx and rd_data SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset: assert rst mid-operation -> coeff_flat=0, cfg_ready=0, busy=0, out_valid=0 with no clock edge required.
REQ-033 Good load: cfg_start, then 33 beats with values 1..33 and cfg_last on beat 33, then commit -> in the next cycle coeff_flat[15:0]=1 and coeff_flat[527:512]=33. With in_valid held high, out_valid stays low for 37 cycles after the swap, then goes high and busy=0.
REQ-034 Short load: cfg_last on beat 10 -> one-cycle load_err, state IDLE, coeff_flat unchanged, and a following commit is ignored.
REQ-035 Restart: cfg_start after 5 beats, then 33 beats of 0x0100 plus commit -> all 33 taps read 0x0100. Also: cfg_start coincident with a beat -> that beat is dropped.
REQ-036 Ignored events: commit in IDLE or FLUSH -> no change to coeff_flat; cfg_start during FLUSH -> cfg_ready stays 0 and FLUSH completes.
REQ-037 With FIR_CTRL_READBACK_EN defined and the REQ-033 load committed -> rd_idx=0 gives 1, rd_idx=32 gives 33, rd_idx=40 gives 0.

Source files
------------

// File: rtl/fir_coeff_ctrl.sv
// rtl/fir_coeff_ctrl.sv - FIR coefficient shadow/active bank loader with flush sequencing.
// Optional readback port enabled by FIR_CTRL_READBACK_EN.
module fir_coeff_ctrl #(
  parameter int NTAPS = 33,
  parameter int CW    = 16,
  parameter int LAT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_data,
  input  logic                cfg_last,
  input  logic                commit,
  output logic                load_err,
  output logic                busy,
  output logic [NTAPS*CW-1:0] coeff_flat,
  input  logic                in_valid,
  output logic                out_valid
`ifdef FIR_CTRL_READBACK_EN
  ,
  input  logic [5:0]          rd_idx,
  output logic [CW-1:0]       rd_data
`endif
);

  localparam int IW = $clog2(NTAPS);
  localparam int FW = $clog2(NTAPS + LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  logic [LAT-1:0]  vld_sr_q, vld_sr_d;
  logic            load_err_q, load_err_d;
  logic [CW-1:0]   shadow_q [NTAPS];
  logic [CW-1:0]   shadow_d [NTAPS];
  logic [CW-1:0]   active_q [NTAPS];
  logic [CW-1:0]   active_d [NTAPS];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    load_err_d = 1'b0;
    // The valid pipe models the datapath and runs regardless of state.
    vld_sr_d   = LAT'({vld_sr_q, in_valid});

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (cfg_start) begin
          idx_d = '0;
        end else if (cfg_valid) begin
          shadow_d[idx_q] = cfg_data;
          if (idx_q == IW'(NTAPS - 1)) begin
            if (cfg_last) begin
              state_d = S_ARMED;
            end else begin
              load_err_d = 1'b1;
              state_d    = S_IDLE;
            end
          end else if (cfg_last) begin
            load_err_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_ARMED: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end else if (commit) begin
          active_d = shadow_q;
          cnt_d    = FW'(NTAPS + LAT - 1);
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - FW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      vld_sr_q   <= '0;
      load_err_q <= 1'b0;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      vld_sr_q   <= vld_sr_d;
      load_err_q <= load_err_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign load_err  = load_err_q;
  assign out_valid = vld_sr_q[LAT-1] && (state_q != S_FLUSH);

  always_comb begin
    coeff_flat = '0;
    for (int k = 0; k < NTAPS; k++) begin
      coeff_flat[k*CW +: CW] = active_q[k];
    end
  end

`ifdef FIR_CTRL_READBACK_EN
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (rd_idx == 6'(k)) rd_data = active_q[k];
    end
  end
`endif

endmodule
